// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi datapath serial/parallel converters.
package viterbi_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_t;

  // Number of serial beats per parallel word (shared with the SIPO block).
  function automatic int piso_depth(input int size_in, input int size_out);
    return size_in / size_out;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat index counter: clears to 0 explicitly and saturates at MAX_COUNT.
// It never wraps by itself, so a missing clear cannot alias onto beat 0.
module beat_counter #(
  parameter int SIZE_DEPTH = 3,
  parameter int MAX_COUNT  = (1 << SIZE_DEPTH) - 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [SIZE_DEPTH-1:0] o_count,
  output logic                  o_max
);

  localparam logic [SIZE_DEPTH-1:0] MaxC = SIZE_DEPTH'(MAX_COUNT);

  logic [SIZE_DEPTH-1:0] count_q;

  assign o_count = count_q;
  assign o_max   = (count_q == MaxC);

  // Count register: clear wins over increment, increment stops at the maximum.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                count_q <= '0;
    else if (i_clr)           count_q <= '0;
    else if (i_inc && !o_max) count_q <= count_q + 1'b1;
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter: one SIZE_DATA_IN word per handshake,
// emitted as DEPTH beats of SIZE_DATA_OUT bits, back-to-back without bubbles.
module piso_serializer
  import viterbi_pkg::*;
#(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 1,
  parameter bit LSB_FIRST     = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic                     o_ready,
  input  logic                     i_en,
  output logic                     o_valid,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_first,
  output logic                     o_last
);

  localparam int DEPTH      = piso_depth(SIZE_DATA_IN, SIZE_DATA_OUT);
  localparam int SIZE_DEPTH = $clog2(DEPTH);
  localparam logic [SIZE_DEPTH-1:0] LastIdx = SIZE_DEPTH'(DEPTH - 1);

  if ((SIZE_DATA_IN % SIZE_DATA_OUT) != 0 || DEPTH < 2) begin : g_bad_param
    $error("piso_serializer: SIZE_DATA_IN must be a multiple of SIZE_DATA_OUT with DEPTH >= 2");
  end

  piso_state_t state_q, state_d;
  logic [DEPTH-1:0][SIZE_DATA_OUT-1:0] word_q;
  logic [SIZE_DEPTH-1:0] count;
  logic [SIZE_DEPTH-1:0] beat_idx;
  logic                  cnt_max;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  accept;
  logic                  shifting;

  beat_counter #(
    .SIZE_DEPTH (SIZE_DEPTH),
    .MAX_COUNT  (DEPTH - 1)
  ) u_beat_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (cnt_clr),
    .i_inc   (cnt_inc),
    .o_count (count),
    .o_max   (cnt_max)
  );

  assign shifting = (state_q == PISO_SHIFT);

  // Ready only looks at state, count and i_en so upstream may derive i_load from it.
  assign o_ready = !shifting || (cnt_max && i_en);
  assign accept  = i_load && o_ready;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= PISO_IDLE;
    else       state_q <= state_d;
  end

  // Next state and counter control; a reload on the last beat keeps the stream contiguous.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      PISO_IDLE: begin
        if (i_load) begin
          cnt_clr = 1'b1;
          state_d = PISO_SHIFT;
        end
      end
      PISO_SHIFT: begin
        if (i_en) begin
          if (cnt_max) begin
            cnt_clr = 1'b1;
            if (!i_load) state_d = PISO_IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = PISO_IDLE;
    endcase
  end

  // Word register: captures only on an accepted handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       word_q <= '0;
    else if (accept) word_q <= i_data;
  end

  // Beat mux: select the slice for the current count; outputs are zero while idle.
  always_comb begin
    beat_idx = LSB_FIRST ? count : (LastIdx - count);
    o_valid  = shifting;
    o_data   = shifting ? word_q[beat_idx] : '0;
    o_first  = shifting && (count == '0);
    o_last   = shifting && cnt_max;
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // 8 -> 1, LSB first
  logic       load0 = 1'b0, en0 = 1'b1;
  logic [7:0] data0 = '0;
  logic       ready0, valid0, first0, last0;
  logic [0:0] dout0;

  // 8 -> 2, MSB first
  logic       load1 = 1'b0, en1 = 1'b1;
  logic [7:0] data1 = '0;
  logic       ready1, valid1, first1, last1;
  logic [1:0] dout1;

  int checks = 0;
  int errors = 0;

  logic [2:0] q0[$];  // {first,last,data}
  logic [3:0] q1[$];  // {first,last,data[1:0]}

  always #5 clk = ~clk;

  piso_serializer #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(1), .LSB_FIRST(1'b1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_load(load0), .i_data(data0), .o_ready(ready0),
    .i_en(en0), .o_valid(valid0), .o_data(dout0), .o_first(first0), .o_last(last0));

  piso_serializer #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(2), .LSB_FIRST(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_load(load1), .i_data(data1), .o_ready(ready1),
    .i_en(en1), .o_valid(valid1), .o_data(dout1), .o_first(first1), .o_last(last1));

  // Scoreboard for dut0: pop on each consumed beat, push on each accepted word.
  initial forever begin
    @(negedge clk);
    if (rst) q0.delete();
    else begin
      if (valid0 && en0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL beat0_extra: got data=%0b first=%0b last=%0b, expected no beat", dout0, first0, last0);
        end else begin
          logic [2:0] e;
          e = q0.pop_front();
          if ({first0, last0, dout0} !== e) begin
            errors++;
            $display("FAIL beat0: got {first,last,data}=%03b expected %03b", {first0, last0, dout0}, e);
          end
        end
      end
      if (!valid0) begin
        checks++;
        if (dout0 !== 1'b0 || first0 !== 1'b0 || last0 !== 1'b0) begin
          errors++;
          $display("FAIL idle0_outputs: got data=%0b first=%0b last=%0b expected 0", dout0, first0, last0);
        end
      end
      if (load0 && ready0)
        for (int k = 0; k < 8; k++) q0.push_back({k == 0, k == 7, data0[k]});
    end
  end

  // Scoreboard for dut1 (MSB-first pairs).
  initial forever begin
    @(negedge clk);
    if (rst) q1.delete();
    else begin
      if (valid1 && en1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL beat1_extra: got data=%02b, expected no beat", dout1);
        end else begin
          logic [3:0] e;
          e = q1.pop_front();
          if ({first1, last1, dout1} !== e) begin
            errors++;
            $display("FAIL beat1: got {first,last,data}=%04b expected %04b", {first1, last1, dout1}, e);
          end
        end
      end
      if (load1 && ready1)
        for (int k = 0; k < 4; k++) q1.push_back({k == 0, k == 3, data1[7-2*k -: 2]});
    end
  end

  task automatic load_word(input bit sel, input logic [7:0] w);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    if (sel) begin load1 = 1'b1; data1 = w; end
    else     begin load0 = 1'b1; data0 = w; end
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = sel ? ready1 : ready0;
      n++;
      if (!ok) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    load0 = 1'b0;
    load1 = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_timeout: word %02h not accepted, ready stayed 0", w);
    end
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? q1.size() : q0.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    checks++;
    if ((sel ? q1.size() : q0.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", sel ? q1.size() : q0.size());
    end
    checks++;
    if ((sel ? valid1 : valid0) !== 1'b0 || (sel ? ready1 : ready0) !== 1'b1) begin
      errors++;
      $display("FAIL after_word: got valid=%0b ready=%0b expected valid=0 ready=1",
               sel ? valid1 : valid0, sel ? ready1 : ready0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || dout0 !== 1'b0 || ready0 !== 1'b1 || first0 !== 1'b0 || last0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b data=%0b ready=%0b first=%0b last=%0b expected 0,0,1,0,0",
               valid0, dout0, ready0, first0, last0);
    end
    checks++;
    if (valid1 !== 1'b0 || dout1 !== 2'b00 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs_w2: got valid=%0b data=%02b ready=%0b expected 0,00,1", valid1, dout1, ready1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: got valid0=%0b valid1=%0b expected 0", valid0, valid1);
      end
    end
  endtask

  task automatic test_single_word();
    load_word(1'b0, 8'hA5);
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    int run;
    run = 0;
    load_word(1'b0, 8'hA5);
    fork
      load_word(1'b0, 8'h3C);
      begin
        repeat (16) begin
          @(negedge clk);
          if (valid0) run++;
        end
      end
    join
    checks++;
    if (run != 16) begin
      errors++;
      $display("FAIL back_to_back_contiguous: got %0d valid beats in 16 cycles, expected 16", run);
    end
    drain(1'b0);
  endtask

  task automatic test_stall_busy();
    load_word(1'b0, 8'hA5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    en0   = 1'b0;
    load0 = 1'b1;
    data0 = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b1 || dout0 !== 1'b1 || first0 !== 1'b0 || last0 !== 1'b0 || ready0 !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%0b data=%0b first=%0b last=%0b ready=%0b expected 1,1,0,0,0",
                 valid0, dout0, first0, last0, ready0);
      end
    end
    @(posedge clk); #1;
    load0 = 1'b0;
    en0   = 1'b1;
    drain(1'b0);
  endtask

  task automatic test_reset_mid_word();
    load_word(1'b0, 8'hA5);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (valid0 !== 1'b0 || dout0 !== 1'b0 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_word: got valid=%0b data=%0b ready=%0b expected 0,0,1", valid0, dout0, ready0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b0) begin
        errors++;
        $display("FAIL residual_beat: got valid=%0b expected 0 after reset", valid0);
      end
    end
    load_word(1'b0, 8'h01);
    drain(1'b0);
  endtask

  task automatic test_param_variant();
    load_word(1'b1, 8'hB4);
    drain(1'b1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall_busy();
    test_reset_mid_word();
    test_param_variant();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
